pseudo_spi_scan_rcv: RTL and testbench

- Receive-side model of the analog scan chain.
- Consumes the two-phase pseudo-SPI stream produced by the SRAM-to-analog serializer: SCLK1, SCLK2, LAT and serial data.
- Rebuilds the parallel configuration word and presents it to the analog-control logic, or to the bench as a golden checker.
- Runs on the same system clock as the serializer and treats the incoming clocks as sampled strobes, not as clocks.

---
 rtl/pseudo_spi_scan_rcv.sv | 84 ++++++++
 tb/tb_pseudo_spi_scan_rcv.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pseudo_spi_scan_rcv.sv
// pseudo_spi_scan_rcv: rebuilds the scan-chain word from a two-phase pseudo-SPI strobe stream.
// Define PSEUDO_SPI_RCV_SYNC_EN to pass the inputs through 2-flop synchronizers (3-cycle event latency).
module pseudo_spi_scan_rcv #(
  parameter int CHAIN_LEN = 64,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 SCLK1,
  input  logic                 SCLK2,
  input  logic                 LAT,
  input  logic                 SI,
  input  logic                 CLR,
  output logic                 SO,
  output logic [CHAIN_LEN-1:0] PO,
  output logic                 LAT_VLD,
  output logic [CNT_WIDTH-1:0] BIT_CNT,
  output logic                 LEN_ERR,
  output logic                 PH_ERR
);
  typedef enum logic {S_IDLE, S_MASTER} state_t;
  state_t state, state_nxt;
  logic [3:0] cur;
  logic [2:0] prev;
  logic master;
  logic [CHAIN_LEN-1:0] chain;
  logic r1, r2, rl, ld_m, shift, ph_set;
  // cur packs {SCLK1, SCLK2, LAT, SI} so SI stays aligned with the strobes
`ifdef PSEUDO_SPI_RCV_SYNC_EN
  logic [3:0] sync1, sync2;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      sync1 <= '0;
      sync2 <= '0;
      cur   <= '0;
      prev  <= '0;
    end else begin
      sync1 <= {SCLK1, SCLK2, LAT, SI};
      sync2 <= sync1;
      cur   <= sync2;
      prev  <= cur[3:1];
    end
`else
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      cur  <= '0;
      prev <= '0;
    end else begin
      cur  <= {SCLK1, SCLK2, LAT, SI};
      prev <= cur[3:1];
    end
`endif
  always_comb begin
    r1        = cur[3] & ~prev[2];
    r2        = cur[2] & ~prev[1];
    rl        = cur[1] & ~prev[0];
    ld_m      = ~rl & r1 & ~r2;
    shift     = ~rl & r2 & ~r1 & (state == S_MASTER);
    ph_set    = ~rl & ((r1 & r2) | (r2 & (state == S_IDLE)) | (r1 & (state == S_MASTER)));
    state_nxt = rl ? S_IDLE : ld_m ? S_MASTER : shift ? S_IDLE : state;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= S_IDLE;
    else state <= state_nxt;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      master  <= 1'b0;
      chain   <= '0;
      PO      <= '0;
      LAT_VLD <= 1'b0;
      BIT_CNT <= '0;
      LEN_ERR <= 1'b0;
      PH_ERR  <= 1'b0;
    end else begin
      LAT_VLD <= rl;
      if (ld_m) master <= cur[0];
      if (shift) chain <= {master, chain[CHAIN_LEN-1:1]};
      if (rl) PO <= chain;
      BIT_CNT <= (CLR || rl) ? '0 : (shift && !(&BIT_CNT)) ? BIT_CNT + 1'b1 : BIT_CNT;
      LEN_ERR <= CLR ? 1'b0 : LEN_ERR | (rl & (BIT_CNT != CNT_WIDTH'(CHAIN_LEN)));
      PH_ERR  <= CLR ? 1'b0 : PH_ERR | ph_set;
    end
  assign SO = chain[0];
endmodule

// File: tb/tb_pseudo_spi_scan_rcv.sv
// tb_pseudo_spi_scan_rcv: directed table plus random strobe stream against a bit-history model,
// on an 8-bit and a 16-bit chain driven in parallel.
module tb_pseudo_spi_scan_rcv;
`ifdef PSEUDO_SPI_RCV_SYNC_EN
  localparam int LCY = 3;
`else
  localparam int LCY = 1;
`endif
  logic clk = 0, rst = 0, sclk1 = 0, sclk2 = 0, lat = 0, si = 0, clr = 0;
  logic so8, so16, vld8, vld16, len8, len16, ph8, ph16;
  logic [7:0] po8, cnt16;
  logic [15:0] po16;
  logic [3:0] cnt8;
  always #5 clk = ~clk;

  pseudo_spi_scan_rcv #(.CHAIN_LEN(8), .CNT_WIDTH(4)) dut8 (
    .CLK(clk), .RST(rst), .SCLK1(sclk1), .SCLK2(sclk2), .LAT(lat), .SI(si), .CLR(clr),
    .SO(so8), .PO(po8), .LAT_VLD(vld8), .BIT_CNT(cnt8), .LEN_ERR(len8), .PH_ERR(ph8));
  pseudo_spi_scan_rcv #(.CHAIN_LEN(16), .CNT_WIDTH(8)) dut16 (
    .CLK(clk), .RST(rst), .SCLK1(sclk1), .SCLK2(sclk2), .LAT(lat), .SI(si), .CLR(clr),
    .SO(so16), .PO(po16), .LAT_VLD(vld16), .BIT_CNT(cnt16), .LEN_ERR(len16), .PH_ERR(ph16));

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: every bit ever shifted since reset, plus a pending phase-1 bit
  bit hist[$];
  bit pend, pend_v, m_ph;
  int m_cnt[2];
  bit m_len[2];
  logic [15:0] m_po[2];

  function automatic int len_of(input int d);
    return d ? 16 : 8;
  endfunction
  function automatic logic [15:0] m_chain(input int d);
    logic [15:0] v = '0;
    for (int i = 0; i < len_of(d); i++) begin
      int idx = hist.size() - len_of(d) + i;
      if (idx >= 0) v[i] = hist[idx];
    end
    return v;
  endfunction

  task automatic drive(input bit a1, input bit a2, input bit al, input bit b, input int hold);
    @(negedge clk);
    sclk1 = a1; sclk2 = a2; lat = al; si = b;
    repeat (hold) @(negedge clk);
    sclk1 = 0; sclk2 = 0; lat = 0;
    repeat (5) @(negedge clk);
  endtask

  task automatic op_s1(input bit b);
    if (pend) m_ph = 1;
    pend = 1; pend_v = b;
    drive(1, 0, 0, b, 1 + int'($urandom_range(0, 2)));
  endtask
  task automatic op_s2();
    if (!pend) m_ph = 1;
    else begin
      hist.push_back(pend_v);
      pend = 0;
      if (m_cnt[0] < 15) m_cnt[0]++;
      if (m_cnt[1] < 255) m_cnt[1]++;
    end
    drive(0, 1, 0, si, 1 + int'($urandom_range(0, 2)));
  endtask
  task automatic op_pair(input bit b);
    op_s1(b);
    op_s2();
  endtask
  task automatic op_both(input bit b);
    m_ph = 1;
    drive(1, 1, 0, b, 2);
  endtask
  task automatic op_lat();
    for (int d = 0; d < 2; d++) begin
      m_po[d] = m_chain(d);
      if (m_cnt[d] != len_of(d)) m_len[d] = 1;
      m_cnt[d] = 0;
    end
    pend = 0;
    @(negedge clk);
    lat = 1;
    for (int c = 1; c <= LCY + 3; c++) begin
      @(posedge clk);
      #1;
      if (c == 2) lat = 0;
      chk($sformatf("vld8_c%0d", c), 32'(vld8), 32'(c == LCY + 1));
      chk($sformatf("vld16_c%0d", c), 32'(vld16), 32'(c == LCY + 1));
    end
    repeat (3) @(negedge clk);
  endtask
  task automatic op_clr();
    m_ph = 0; m_len = '{0, 0}; m_cnt = '{0, 0};
    @(negedge clk); clr = 1;
    @(negedge clk); clr = 0;
    repeat (2) @(negedge clk);
  endtask
  task automatic op_rst();
    hist.delete();
    pend = 0; m_ph = 0; m_len = '{0, 0}; m_cnt = '{0, 0}; m_po = '{16'h0, 16'h0};
    @(negedge clk); rst = 1;
    #1;
    chk("rst_po8", 32'(po8), 0);
    chk("rst_po16", 32'(po16), 0);
    chk("rst_cnt8", 32'(cnt8), 0);
    chk("rst_errs", 32'({len8, ph8, len16, ph16}), 0);
    chk("rst_vld_so", 32'({vld8, vld16, so8, so16}), 0);
    @(negedge clk); rst = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    logic [15:0] c8 = m_chain(0), c16 = m_chain(1);
    chk({tag, "_po8"}, 32'(po8), 32'(m_po[0][7:0]));
    chk({tag, "_po16"}, 32'(po16), 32'(m_po[1]));
    chk({tag, "_cnt8"}, 32'(cnt8), 32'(m_cnt[0]));
    chk({tag, "_cnt16"}, 32'(cnt16), 32'(m_cnt[1]));
    chk({tag, "_len"}, 32'({len8, len16}), 32'({m_len[0], m_len[1]}));
    chk({tag, "_ph"}, 32'({ph8, ph16}), 32'({m_ph, m_ph}));
    chk({tag, "_so"}, 32'({so8, so16}), 32'({c8[0], c16[0]}));
  endtask

  typedef enum int {T_RST, T_BYTE, T_BIT, T_LAT, T_CLR, T_S2, T_BOTH} top_e;
  typedef struct {
    top_e op;
    logic [7:0] arg;
    logic [7:0] po;
    logic [3:0] cnt;
    logic len;
    logic ph;
  } vec_t;
  vec_t tv[$];

  initial begin
    tv.push_back('{T_RST,  8'h00, 8'h00, 4'd0,  1'b0, 1'b0});
    tv.push_back('{T_BYTE, 8'hA5, 8'h00, 4'd8,  1'b0, 1'b0});
    tv.push_back('{T_LAT,  8'h00, 8'hA5, 4'd0,  1'b0, 1'b0});
    tv.push_back('{T_BYTE, 8'h5A, 8'hA5, 4'd8,  1'b0, 1'b0});
    tv.push_back('{T_BIT,  8'h01, 8'hA5, 4'd9,  1'b0, 1'b0});
    tv.push_back('{T_BIT,  8'h01, 8'hA5, 4'd10, 1'b0, 1'b0});
    tv.push_back('{T_LAT,  8'h00, 8'hD6, 4'd0,  1'b1, 1'b0});
    tv.push_back('{T_BYTE, 8'hFF, 8'hD6, 4'd8,  1'b1, 1'b0});
    tv.push_back('{T_LAT,  8'h00, 8'hFF, 4'd0,  1'b1, 1'b0});
    tv.push_back('{T_CLR,  8'h00, 8'hFF, 4'd0,  1'b0, 1'b0});
    tv.push_back('{T_S2,   8'h00, 8'hFF, 4'd0,  1'b0, 1'b1});
    tv.push_back('{T_CLR,  8'h00, 8'hFF, 4'd0,  1'b0, 1'b0});
    tv.push_back('{T_BIT,  8'h01, 8'hFF, 4'd1,  1'b0, 1'b0});
    tv.push_back('{T_BOTH, 8'h00, 8'hFF, 4'd1,  1'b0, 1'b1});
    tv.push_back('{T_CLR,  8'h00, 8'hFF, 4'd0,  1'b0, 1'b0});
    tv.push_back('{T_BIT,  8'h01, 8'hFF, 4'd1,  1'b0, 1'b0});
    tv.push_back('{T_BIT,  8'h00, 8'hFF, 4'd2,  1'b0, 1'b0});
    tv.push_back('{T_BIT,  8'h01, 8'hFF, 4'd3,  1'b0, 1'b0});
    tv.push_back('{T_RST,  8'h00, 8'h00, 4'd0,  1'b0, 1'b0});
    tv.push_back('{T_BYTE, 8'hFF, 8'h00, 4'd8,  1'b0, 1'b0});
    tv.push_back('{T_LAT,  8'h00, 8'hFF, 4'd0,  1'b0, 1'b0});
    tv.push_back('{T_RST,  8'h00, 8'h00, 4'd0,  1'b0, 1'b0});
    tv.push_back('{T_BYTE, 8'h3C, 8'h00, 4'd8,  1'b0, 1'b0});
    tv.push_back('{T_BYTE, 8'h81, 8'h00, 4'd15, 1'b0, 1'b0});
    tv.push_back('{T_LAT,  8'h00, 8'h81, 4'd0,  1'b1, 1'b0});
    foreach (tv[i]) begin
      case (tv[i].op)
        T_RST:   op_rst();
        T_BYTE:  for (int k = 0; k < 8; k++) op_pair(tv[i].arg[k]);
        T_BIT:   op_pair(tv[i].arg[0]);
        T_LAT:   op_lat();
        T_CLR:   op_clr();
        T_S2:    op_s2();
        default: op_both(tv[i].arg[0]);
      endcase
      chk($sformatf("t%0d_po", i), 32'(po8), 32'(tv[i].po));
      chk($sformatf("t%0d_cnt", i), 32'(cnt8), 32'(tv[i].cnt));
      chk($sformatf("t%0d_len", i), 32'(len8), 32'(tv[i].len));
      chk($sformatf("t%0d_ph", i), 32'(ph8), 32'(tv[i].ph));
      check_model($sformatf("t%0d", i));
    end
    chk("frame16_po", 32'(po16), 32'h813C);
    chk("frame16_so", 32'(so16), 0);
    chk("frame16_len", 32'(len16), 0);
    op_clr();
    for (int n = 0; n < 250; n++) begin
      int r = int'($urandom_range(0, 99));
      if (r < 40) op_pair(1'($urandom));
      else if (r < 52) op_s1(1'($urandom));
      else if (r < 62) op_s2();
      else if (r < 68) op_both(1'($urandom));
      else if (r < 80) op_lat();
      else if (r < 86) op_clr();
      else if (r < 89) op_rst();
      else begin
        logic [15:0] w = 16'($urandom);
        int nb = ($urandom_range(0, 1) != 0) ? 16 : 8;
        for (int k = 0; k < nb; k++) op_pair(w[k]);
        op_lat();
      end
      check_model($sformatf("r%0d", n));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
